// File: rtl/pcd_frame_decoder_pkg.sv
// Shared types and CRC_A helpers for the PCD->PICC frame decoding path.
package pcd_frame_decoder_pkg;

   typedef enum logic [1:0] {
      SEQ_X     = 2'd0,
      SEQ_Y     = 2'd1,
      SEQ_Z     = 2'd2,
      SEQ_ERROR = 2'd3
   } PCDBitSequence;

   typedef enum logic [1:0] {
      FD_IDLE = 2'd0,
      FD_RX   = 2'd1,
      FD_DROP = 2'd2
   } FrameDecodeState;

   localparam logic [15:0] CRC_A_INIT           = 16'h6363;
   localparam logic [15:0] CRC_A_POLY_REFLECTED = 16'h8408;

   // One byte of reflected CRC_A, LSb of the byte first.
   function automatic logic [15:0] crc_a_update(input logic [15:0] crc_in,
                                                input logic [7:0]  dat);
      logic [15:0] c;
      c = crc_in;
      for (int i = 0; i < 8; i++) begin
         if (c[0] ^ dat[i]) c = (c >> 1) ^ CRC_A_POLY_REFLECTED;
         else               c = c >> 1;
      end
      return c;
   endfunction

endpackage

// File: rtl/crc_a_byte.sv
// Registered bytewise CRC_A accumulator; also used by the PICC transmit path.
module crc_a_byte
   import pcd_frame_decoder_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        init,
   input  logic        en,
   input  logic [7:0]  data,
   output logic [15:0] crc
);

   // init has priority so a new frame never inherits a stale residue
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    crc <= CRC_A_INIT;
      else if (init) crc <= CRC_A_INIT;
      else if (en)   crc <= crc_a_update(crc, data);
   end

endmodule

// File: rtl/pcd_frame_decoder.sv
// Miller sequence to byte decoder with odd parity, bit-oriented alignment,
// CRC_A residue check and frame length limit.
//
// state   | meaning
// --------+---------------------------------------------------------------
// FD_IDLE | waiting for Z (start of communication)
// FD_RX   | decoding data/parity bits, last bit held pending one symbol
// FD_DROP | frame aborted, silent until the end-of-communication pattern
module pcd_frame_decoder
   import pcd_frame_decoder_pkg::*;
#(
   parameter int MAX_FRAME_BYTES = 64,
   parameter bit CRC_CHECK_EN    = 1'b1
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  PCDBitSequence                        sd_seq,
   input  logic                                 sd_seq_valid,
   input  logic [2:0]                           rx_align,
   output logic                                 soc,
   output logic                                 eoc,
   output logic [7:0]                           data,
   output logic [2:0]                           data_bits,
   output logic                                 data_valid,
   output logic                                 sequence_error,
   output logic                                 parity_error,
   output logic                                 overflow,
   output logic                                 crc_ok,
   output logic [$clog2(MAX_FRAME_BYTES+1)-1:0] byte_count
);

   localparam int BCW = $clog2(MAX_FRAME_BYTES + 1);

   FrameDecodeState state_q, state_d;
   logic [2:0]      align_q, align_d;
   logic [3:0]      bit_pos_q, bit_pos_d;      // 8 means next bit is parity
   logic [7:0]      shreg_q, shreg_d;
   logic            pend_vld_q, pend_vld_d;
   logic            pend_bit_q, pend_bit_d;
   logic            prev_x_q, prev_x_d;
   logic            prev_zero_q, prev_zero_d;  // SOC counts as a 0-symbol
   logic [BCW-1:0]  byte_count_q, byte_count_d;

   logic            soc_q, soc_d, eoc_q, eoc_d;
   logic [7:0]      data_q, data_d;
   logic [2:0]      data_bits_q, data_bits_d;
   logic            data_valid_q, data_valid_d;
   logic            seq_err_q, seq_err_d;
   logic            par_err_q, par_err_d;
   logic            overflow_q, overflow_d;
   logic            crc_ok_q, crc_ok_d;

   logic            crc_init, crc_en;
   logic [15:0]     crc_val;
   logic [3:0]      first_pos;
   logic [3:0]      nbits;
   logic            new_bit;

   if (CRC_CHECK_EN) begin : g_crc
      crc_a_byte u_crc (
         .clk   (clk),
         .rst_n (rst_n),
         .init  (crc_init),
         .en    (crc_en),
         .data  (shreg_q),
         .crc   (crc_val)
      );
   end else begin : g_no_crc
      assign crc_val = 16'h0000;
   end

   // Next-state and registered-output decode for one symbol strobe
   always_comb begin
      state_d      = state_q;
      align_d      = align_q;
      bit_pos_d    = bit_pos_q;
      shreg_d      = shreg_q;
      pend_vld_d   = pend_vld_q;
      pend_bit_d   = pend_bit_q;
      prev_x_d     = prev_x_q;
      prev_zero_d  = prev_zero_q;
      byte_count_d = byte_count_q;
      soc_d        = 1'b0;
      eoc_d        = 1'b0;
      data_d       = data_q;
      data_bits_d  = 3'd0;
      data_valid_d = 1'b0;
      seq_err_d    = 1'b0;
      par_err_d    = 1'b0;
      overflow_d   = 1'b0;
      crc_ok_d     = 1'b0;
      crc_init     = 1'b0;
      crc_en       = 1'b0;
      first_pos    = (byte_count_q == '0) ? {1'b0, align_q} : 4'd0;
      nbits        = bit_pos_q - first_pos;
      new_bit      = (sd_seq == SEQ_X);

      if (sd_seq_valid) begin
         case (state_q)
            FD_IDLE: begin
               if (sd_seq == SEQ_Z) begin
                  state_d      = FD_RX;
                  soc_d        = 1'b1;
                  align_d      = rx_align;
                  bit_pos_d    = {1'b0, rx_align};
                  shreg_d      = 8'h00;
                  pend_vld_d   = 1'b0;
                  prev_x_d     = 1'b0;
                  prev_zero_d  = 1'b1;
                  byte_count_d = '0;
                  crc_init     = 1'b1;
               end
            end

            FD_RX: begin
               if (sd_seq == SEQ_ERROR || (sd_seq == SEQ_Z && prev_x_q)) begin
                  seq_err_d   = 1'b1;
                  state_d     = FD_DROP;
                  prev_x_d    = 1'b0;
                  prev_zero_d = (sd_seq == SEQ_Z);
               end else if (sd_seq == SEQ_Y && prev_zero_q) begin
                  // the pending 0 belongs to the EOC pattern and is discarded
                  eoc_d   = 1'b1;
                  state_d = FD_IDLE;
                  if (bit_pos_q[3]) begin
                     par_err_d = 1'b1;
                  end else if (byte_count_q == '0 && bit_pos_q == {1'b0, align_q}) begin
                     seq_err_d = 1'b1;
                  end else if (bit_pos_q != first_pos) begin
                     data_bits_d = nbits[2:0];
                     data_d      = shreg_q >> first_pos;
                  end else begin
                     crc_ok_d = CRC_CHECK_EN && (32'(byte_count_q) >= 32'd3) &&
                                (crc_val == 16'h0000);
                  end
               end else begin
                  if (pend_vld_q) begin
                     if (bit_pos_q[3]) begin
                        if (^{shreg_q, pend_bit_q}) begin
                           if (byte_count_q == BCW'(MAX_FRAME_BYTES)) begin
                              overflow_d = 1'b1;
                              state_d    = FD_DROP;
                           end else begin
                              data_valid_d = 1'b1;
                              data_d       = shreg_q;
                              crc_en       = 1'b1;
                              byte_count_d = byte_count_q + BCW'(1);
                              bit_pos_d    = 4'd0;
                              shreg_d      = 8'h00;
                           end
                        end else begin
                           par_err_d = 1'b1;
                           state_d   = FD_DROP;
                        end
                     end else begin
                        shreg_d[bit_pos_q[2:0]] = pend_bit_q;
                        bit_pos_d               = bit_pos_q + 4'd1;
                     end
                  end
                  pend_vld_d  = 1'b1;
                  pend_bit_d  = new_bit;
                  prev_x_d    = new_bit;
                  prev_zero_d = !new_bit;
               end
            end

            FD_DROP: begin
               if (sd_seq == SEQ_Y && prev_zero_q) begin
                  eoc_d   = 1'b1;
                  state_d = FD_IDLE;
               end
               prev_x_d    = (sd_seq == SEQ_X);
               prev_zero_d = (sd_seq == SEQ_Y || sd_seq == SEQ_Z);
            end

            default: state_d = FD_IDLE;
         endcase
      end
   end

   // State, datapath and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= FD_IDLE;
         align_q      <= 3'd0;
         bit_pos_q    <= 4'd0;
         shreg_q      <= 8'h00;
         pend_vld_q   <= 1'b0;
         pend_bit_q   <= 1'b0;
         prev_x_q     <= 1'b0;
         prev_zero_q  <= 1'b0;
         byte_count_q <= '0;
         soc_q        <= 1'b0;
         eoc_q        <= 1'b0;
         data_q       <= 8'h00;
         data_bits_q  <= 3'd0;
         data_valid_q <= 1'b0;
         seq_err_q    <= 1'b0;
         par_err_q    <= 1'b0;
         overflow_q   <= 1'b0;
         crc_ok_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         align_q      <= align_d;
         bit_pos_q    <= bit_pos_d;
         shreg_q      <= shreg_d;
         pend_vld_q   <= pend_vld_d;
         pend_bit_q   <= pend_bit_d;
         prev_x_q     <= prev_x_d;
         prev_zero_q  <= prev_zero_d;
         byte_count_q <= byte_count_d;
         soc_q        <= soc_d;
         eoc_q        <= eoc_d;
         data_q       <= data_d;
         data_bits_q  <= data_bits_d;
         data_valid_q <= data_valid_d;
         seq_err_q    <= seq_err_d;
         par_err_q    <= par_err_d;
         overflow_q   <= overflow_d;
         crc_ok_q     <= crc_ok_d;
      end
   end

   assign soc            = soc_q;
   assign eoc            = eoc_q;
   assign data           = data_q;
   assign data_bits      = data_bits_q;
   assign data_valid     = data_valid_q;
   assign sequence_error = seq_err_q;
   assign parity_error   = par_err_q;
   assign overflow       = overflow_q;
   assign crc_ok         = crc_ok_q;
   assign byte_count     = byte_count_q;

endmodule

// File: tb/tb_pcd_frame_decoder.sv
// Directed bench for pcd_frame_decoder (frame limit 4 bytes).
module tb_pcd_frame_decoder;
   import pcd_frame_decoder_pkg::*;

   logic          clk = 1'b0;
   logic          rst_n;
   PCDBitSequence sd_seq;
   logic          sd_seq_valid;
   logic [2:0]    rx_align;
   logic          soc, eoc, data_valid, sequence_error, parity_error, overflow, crc_ok;
   logic [7:0]    data;
   logic [2:0]    data_bits;
   logic [2:0]    byte_count;

   int vectors = 0;
   int miscompares = 0;

   int         soc_cnt, eoc_cnt, dv_cnt, serr_cnt, perr_cnt, ovf_cnt;
   int         clash_cnt = 0;
   logic [7:0] dv_bytes [0:7];
   logic [2:0] eoc_bits, eoc_bc;
   logic [7:0] eoc_data;
   logic       eoc_crc, eoc_perr, eoc_serr;
   logic       clr_tog = 1'b0;
   logic       clr_seen = 1'b0;
   logic       prev_x;
   logic [7:0] tmp;

   PCDBitSequence frame1 [0:11] = '{SEQ_Z, SEQ_X, SEQ_Y, SEQ_Z, SEQ_X, SEQ_Y,
                                    SEQ_X, SEQ_Y, SEQ_Z, SEQ_Z, SEQ_Z, SEQ_Y};

   pcd_frame_decoder #(.MAX_FRAME_BYTES(4)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .sd_seq         (sd_seq),
      .sd_seq_valid   (sd_seq_valid),
      .rx_align       (rx_align),
      .soc            (soc),
      .eoc            (eoc),
      .data           (data),
      .data_bits      (data_bits),
      .data_valid     (data_valid),
      .sequence_error (sequence_error),
      .parity_error   (parity_error),
      .overflow       (overflow),
      .crc_ok         (crc_ok),
      .byte_count     (byte_count)
   );

   always #5 clk = ~clk;

   // pulse monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (clr_tog != clr_seen) begin
         clr_seen = clr_tog;
         soc_cnt = 0; eoc_cnt = 0; dv_cnt = 0; serr_cnt = 0; perr_cnt = 0; ovf_cnt = 0;
         eoc_bits = 3'd7; eoc_bc = 3'd7; eoc_data = 8'hEE;
         eoc_crc = 1'bx; eoc_perr = 1'bx; eoc_serr = 1'bx;
      end
      if (soc) soc_cnt++;
      if (data_valid) begin
         dv_bytes[dv_cnt[2:0]] = data;
         dv_cnt++;
      end
      if (sequence_error) serr_cnt++;
      if (parity_error)   perr_cnt++;
      if (overflow)       ovf_cnt++;
      if (data_valid && (sequence_error || parity_error || overflow)) clash_cnt++;
      if (eoc) begin
         eoc_cnt++;
         eoc_bits = data_bits;
         eoc_data = data;
         eoc_crc  = crc_ok;
         eoc_bc   = byte_count;
         eoc_perr = parity_error;
         eoc_serr = sequence_error;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      clr_tog = ~clr_tog;
      @(negedge clk); #1;
   endtask

   task automatic sym(input PCDBitSequence s);
      @(posedge clk); #1;
      sd_seq = s;
      sd_seq_valid = 1'b1;
      @(posedge clk); #1;
      sd_seq_valid = 1'b0;
      @(negedge clk); #1;
   endtask

   task automatic tx_soc();
      sym(SEQ_Z);
      prev_x = 1'b0;
   endtask

   task automatic tx_bit(input logic b);
      if (b) begin
         sym(SEQ_X);
         prev_x = 1'b1;
      end else begin
         sym(prev_x ? SEQ_Y : SEQ_Z);
         prev_x = 1'b0;
      end
   endtask

   task automatic tx_byte(input logic [7:0] d, input logic flip);
      for (int i = 0; i < 8; i++) tx_bit(d[i]);
      tx_bit((~^d) ^ flip);
   endtask

   task automatic tx_eoc();
      tx_bit(1'b0);
      sym(SEQ_Y);
      prev_x = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; sd_seq = SEQ_X; sd_seq_valid = 1'b0; rx_align = 3'd0; prev_x = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pulses", 32'({soc, eoc, data_valid, sequence_error, parity_error, overflow, crc_ok}), 0);
      chk("rst_data", 32'(data), 0);
      chk("rst_bits", 32'(data_bits), 0);
      chk("rst_bc", 32'(byte_count), 0);
      rst_n = 1'b1;
      clr();

      // non-Z symbols in idle are ignored
      sym(SEQ_X); sym(SEQ_Y); sym(SEQ_ERROR);
      chk("idle_soc", soc_cnt, 0);
      chk("idle_serr", serr_cnt, 0);

      // LSb first: 0x29
      clr();
      sym(SEQ_Z);
      chk("lsb_soc_lat", 32'(soc), 1);
      for (int k = 1; k < 12; k++) sym(frame1[k]);
      chk("lsb_soc", soc_cnt, 1);
      chk("lsb_dv", dv_cnt, 1);
      chk("lsb_byte", 32'(dv_bytes[0]), 32'h29);
      chk("lsb_eoc", eoc_cnt, 1);
      chk("lsb_bits", 32'(eoc_bits), 0);
      chk("lsb_bc", 32'(eoc_bc), 1);
      chk("lsb_crc", 32'(eoc_crc), 0);
      chk("lsb_bc_hold", 32'(byte_count), 1);

      // HLTA with valid CRC_A
      clr();
      tx_soc();
      tx_byte(8'h50, 1'b0); tx_byte(8'h00, 1'b0); tx_byte(8'h57, 1'b0); tx_byte(8'hCD, 1'b0);
      tx_eoc();
      chk("crc_dv", dv_cnt, 4);
      chk("crc_b3", 32'(dv_bytes[3]), 32'hCD);
      chk("crc_bc", 32'(eoc_bc), 4);
      chk("crc_ok", 32'(eoc_crc), 1);

      // one data bit flipped, parity still good
      clr();
      tx_soc();
      tx_byte(8'h50, 1'b0); tx_byte(8'h01, 1'b0); tx_byte(8'h57, 1'b0); tx_byte(8'hCD, 1'b0);
      tx_eoc();
      chk("crcbad_dv", dv_cnt, 4);
      chk("crcbad_b1", 32'(dv_bytes[1]), 32'h01);
      chk("crcbad_ok", 32'(eoc_crc), 0);

      // anticollision, first data bit at position 3
      clr();
      rx_align = 3'd3;
      tx_soc();
      rx_align = 3'd0;
      tx_bit(1'b1); tx_bit(1'b0); tx_bit(1'b1); tx_bit(1'b1); tx_bit(1'b0);
      tx_bit(1'b0);
      tx_byte(8'hA5, 1'b0);
      tmp = 8'h3C;
      for (int i = 0; i < 8; i++) tx_bit(tmp[i]);
      tx_eoc();
      chk("ac_dv", dv_cnt, 2);
      chk("ac_b0", 32'(dv_bytes[0]), 32'h68);
      chk("ac_b1", 32'(dv_bytes[1]), 32'hA5);
      chk("ac_eoc", eoc_cnt, 1);
      chk("ac_bits", 32'(eoc_bits), 0);
      chk("ac_eoc_perr", 32'(eoc_perr), 1);
      chk("ac_perr_cnt", perr_cnt, 1);
      chk("ac_bc", 32'(eoc_bc), 2);

      // parity-1 byte is delivered only after the following symbol; partial tail
      clr();
      tx_soc();
      tmp = 8'h5A;
      for (int i = 0; i < 8; i++) tx_bit(tmp[i]);
      tx_bit(1'b1);
      chk("lag_dv_before", dv_cnt, 0);
      tx_bit(1'b1);
      chk("lag_dv_after", dv_cnt, 1);
      chk("lag_byte", 32'(dv_bytes[0]), 32'h5A);
      tx_bit(1'b1); tx_bit(1'b0);
      tx_eoc();
      chk("part_bits", 32'(eoc_bits), 3);
      chk("part_data", 32'(eoc_data), 3);
      chk("part_bc", 32'(eoc_bc), 1);
      chk("part_crc", 32'(eoc_crc), 0);

      // parity of byte 2 flipped
      clr();
      tx_soc();
      tx_byte(8'h11, 1'b0); tx_byte(8'h22, 1'b0); tx_byte(8'h33, 1'b1);
      tx_byte(8'h44, 1'b0); tx_byte(8'h55, 1'b0);
      tx_eoc();
      chk("par_dv", dv_cnt, 2);
      chk("par_perr", perr_cnt, 1);
      chk("par_eoc", eoc_cnt, 1);
      chk("par_eoc_perr", 32'(eoc_perr), 0);
      chk("par_bc", 32'(eoc_bc), 2);

      // 6 bytes against a 4-byte limit
      clr();
      tx_soc();
      for (int b = 1; b <= 6; b++) tx_byte(8'(b), 1'b0);
      tx_eoc();
      chk("ovf_dv", dv_cnt, 4);
      chk("ovf_b3", 32'(dv_bytes[3]), 32'h04);
      chk("ovf_cnt", ovf_cnt, 1);
      chk("ovf_eoc", eoc_cnt, 1);
      chk("ovf_bc", 32'(eoc_bc), 4);
      chk("ovf_crc", 32'(eoc_crc), 0);

      // ERROR symbol at each position of a one-byte frame
      for (int i = 1; i <= 9; i++) begin
         clr();
         for (int k = 0; k < 12; k++) sym((k == i) ? SEQ_ERROR : frame1[k]);
         chk($sformatf("seqerr%0d_serr", i), serr_cnt, 1);
         chk($sformatf("seqerr%0d_eoc", i), eoc_cnt, 1);
         chk($sformatf("seqerr%0d_dv", i), dv_cnt, 0);
      end

      // Z directly after X
      clr();
      sym(SEQ_Z); sym(SEQ_X); sym(SEQ_Z); sym(SEQ_Y);
      chk("zx_serr", serr_cnt, 1);
      chk("zx_eoc", eoc_cnt, 1);

      // empty frames
      clr();
      sym(SEQ_Z); sym(SEQ_Y);
      chk("zy_soc", soc_cnt, 1);
      chk("zy_eoc", eoc_cnt, 1);
      chk("zy_serr", 32'(eoc_serr), 1);
      clr();
      sym(SEQ_Z); sym(SEQ_Z); sym(SEQ_Y);
      chk("zzy_eoc", eoc_cnt, 1);
      chk("zzy_serr", 32'(eoc_serr), 1);
      chk("zzy_dv", dv_cnt, 0);

      // reset in the middle of the second byte
      clr();
      tx_soc();
      tx_byte(8'h29, 1'b0);
      tx_bit(1'b1); tx_bit(1'b0);
      chk("mid_bc_pre", 32'(byte_count), 1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #2;
      chk("mid_rst_out", 32'({soc, eoc, data_valid, sequence_error, parity_error, overflow, crc_ok}), 0);
      chk("mid_rst_bc", 32'(byte_count), 0);
      chk("mid_rst_data", 32'(data), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      clr();
      repeat (4) @(posedge clk);
      #1;
      chk("mid_no_eoc", eoc_cnt, 0);
      tx_soc();
      chk("mid_soc", 32'(soc), 1);
      tx_byte(8'h81, 1'b0);
      tx_eoc();
      chk("mid_dv", dv_cnt, 1);
      chk("mid_byte", 32'(dv_bytes[0]), 32'h81);
      chk("mid_bc", 32'(eoc_bc), 1);

      chk("no_err_with_dv", clash_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
